// File: rtl/x_pkg.sv
// Shared types and default timing constants for the PLL-domain reset sequencer.
package x_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } t_rst_seq_state;

    localparam int C_SETTLE_CYCLES = 1024;
    localparam int C_HOLD_CYCLES   = 16;

endpackage

// File: rtl/x_sync.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module x_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [P_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[P_SYNC_STAGES-1];

endmodule

// File: rtl/x_pll_rst_seq.sv
// PLL-domain reset sequencer: waits for a stable synchronised LOCK, releases reset,
// re-asserts it for a minimum hold on lock loss or soft request, and counts losses.
module x_pll_rst_seq
    import x_pkg::*;
#(
    parameter int P_SYNC_STAGES   = 2,
    parameter int P_SETTLE_CYCLES = C_SETTLE_CYCLES,
    parameter int P_HOLD_CYCLES   = C_HOLD_CYCLES,
    parameter int P_CNT_W         = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_lock,
    input  logic               i_req_rst,
    output logic               o_rst,
    output logic               o_ready,
    output logic [P_CNT_W-1:0] o_loss_cnt,
    output logic [1:0]         o_state
);

    localparam int C_SET_W  = $clog2(P_SETTLE_CYCLES);
    localparam int C_HOLD_W = (P_HOLD_CYCLES > 1) ? $clog2(P_HOLD_CYCLES) : 1;
    localparam logic [C_SET_W-1:0]  C_SET_LAST  = C_SET_W'(P_SETTLE_CYCLES - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(P_HOLD_CYCLES - 1);

    logic                lock_s;
    t_rst_seq_state      state, state_n;
    logic [C_SET_W-1:0]  settle_cnt, settle_n;
    logic [C_HOLD_W-1:0] hold_cnt, hold_n;
    logic                loss_inc;

    x_sync #(
        .P_SYNC_STAGES(P_SYNC_STAGES)
    ) u_lock_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_lock),
        .o_q  (lock_s)
    );

    always_comb begin
        state_n  = state;
        settle_n = settle_cnt;
        hold_n   = hold_cnt;
        loss_inc = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n  = SETTLE;
                    settle_n = '0;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_n  = WAIT_LOCK;
                    settle_n = '0;
                end else if (settle_cnt == C_SET_LAST) begin
                    state_n = RUN;
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n  = HOLD;
                    hold_n   = '0;
                    loss_inc = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == C_HOLD_LAST) begin
                    state_n = WAIT_LOCK;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = WAIT_LOCK;
        endcase
        // A soft request overrides everything except an ongoing hold; a coincident loss still counts.
        if (i_req_rst && (state != HOLD)) begin
            state_n = HOLD;
            hold_n  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            o_rst      <= 1'b1;
            o_ready    <= 1'b0;
            o_loss_cnt <= '0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
            hold_cnt   <= hold_n;
            o_rst      <= (state_n != RUN);
            o_ready    <= (state_n == RUN);
            if (loss_inc && (o_loss_cnt != '1)) begin
                o_loss_cnt <= o_loss_cnt + 1'b1;
            end
        end
    end

    assign o_state = state;

endmodule
